// File: rtl/audio_test_tone_source.sv
// Stereo PCM test-tone source: fractional sample-rate generator, square/triangle/sawtooth
// phase-accumulator synthesis, and a small frame FIFO drained over a valid/ready stream.
module audio_test_tone_source #(
  parameter int unsigned CLOCK_HZ    = 74250000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] phaseStep,
  input  logic [1:0]  waveform,
  input  logic [3:0]  attenuation,
  input  logic        rightInvert,
  input  logic        clearOverflow,
  output logic        sampleTick,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] outLeft,
  output logic [15:0] outRight,
  output logic        outBlockStart,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [32:0] CLK_W  = 33'(CLOCK_HZ);
  localparam logic [32:0] RATE_W = 33'(SAMPLE_RATE);
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_TRIANGLE = 2'd1,
    WAVE_SAWTOOTH = 2'd2,
    WAVE_SILENCE  = 2'd3
  } wave_e;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic        block_start;
  } frame_t;

  // Rate generator: adding SAMPLE_RATE and wrapping at CLOCK_HZ gives exactly
  // SAMPLE_RATE ticks per CLOCK_HZ cycles with no accumulated drift.
  logic [31:0] rate_acc;
  logic [32:0] rate_sum;
  logic        tick;

  always_comb begin
    rate_sum = {1'b0, rate_acc} + RATE_W;
    tick     = (rate_sum >= CLK_W);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)     rate_acc <= '0;
    else if (tick) rate_acc <= 32'(rate_sum - CLK_W);
    else           rate_acc <= rate_sum[31:0];
  end

  assign sampleTick = tick;

  // Tone synthesis from the top 16 bits of the phase accumulator.
  logic [23:0] phase;
  logic [15:0] p;
  logic [14:0] tri_mag;
  logic [15:0] raw;
  logic [15:0] left_s;
  logic [15:0] right_s;

  // NOTE: every combinationally driven signal gets a default first so no latch can be inferred.
  always_comb begin
    p       = phase[23:8];
    tri_mag = p[15] ? ~p[14:0] : p[14:0];
    raw     = '0;
    case (wave_e'(waveform))
      WAVE_SQUARE:   raw = p[15] ? 16'h8001 : 16'h7FFF;
      WAVE_TRIANGLE: raw = {tri_mag, 1'b0} ^ 16'h8000;
      WAVE_SAWTOOTH: raw = p ^ 16'h8000;
      default:       raw = '0;
    endcase
    left_s = 16'($signed(raw) >>> attenuation);
    if (!rightInvert)            right_s = left_s;
    else if (left_s == 16'h8000) right_s = 16'h7FFF;
    else                         right_s = 16'(-$signed(left_s));
  end

  always_ff @(posedge clock) begin
    if (reset)       phase <= '0;
    else if (!enable) phase <= '0;
    else if (tick)   phase <= phase + phaseStep;
  end

  // One-frame staging register: the frame computed on a tick is pushed on the next cycle.
  logic        pend_valid;
  logic [15:0] pend_left;
  logic [15:0] pend_right;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_left  <= '0;
      pend_right <= '0;
    end else begin
      pend_valid <= tick & enable;
      if (tick & enable) begin
        pend_left  <= left_s;
        pend_right <= right_s;
      end
    end
  end

  // Frame FIFO.
  frame_t           mem [FIFO_DEPTH];
  frame_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [7:0]       frame_index;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH_W);
    pop   = !empty && outReady;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push  = pend_valid && (!full || pop);
    drop  = pend_valid && full && !pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_index <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        frame_index <= (frame_index == 8'd191) ? 8'd0 : frame_index + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  // NOTE: frame storage is deliberately not reset; outputs are forced to zero while empty instead.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{left: pend_left, right: pend_right, block_start: (frame_index == 8'd0)};
  end

  always_comb begin
    head          = mem[rd_ptr];
    outValid      = !empty;
    outLeft       = empty ? 16'h0000 : head.left;
    outRight      = empty ? 16'h0000 : head.right;
    outBlockStart = !empty && head.block_start;
  end

endmodule

// File: tb/tb_audio_test_tone_source.sv
// Directed bench for audio_test_tone_source with CLOCK_HZ=100, SAMPLE_RATE=30, FIFO_DEPTH=4,
// so ticks arrive every 3-4 cycles and every scenario stays short.
module tb_audio_test_tone_source;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] phaseStep;
  logic [1:0]  waveform;
  logic [3:0]  attenuation;
  logic        rightInvert;
  logic        clearOverflow;
  logic        sampleTick;
  logic        outValid;
  logic        outReady;
  logic [15:0] outLeft;
  logic [15:0] outRight;
  logic        outBlockStart;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic        bs;
  } rec_t;

  rec_t frames[$];

  audio_test_tone_source #(
    .CLOCK_HZ(100),
    .SAMPLE_RATE(30),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .phaseStep(phaseStep),
    .waveform(waveform),
    .attenuation(attenuation),
    .rightInvert(rightInvert),
    .clearOverflow(clearOverflow),
    .sampleTick(sampleTick),
    .outValid(outValid),
    .outReady(outReady),
    .outLeft(outLeft),
    .outRight(outRight),
    .outBlockStart(outBlockStart),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Records each frame the consumer accepts; inputs are stable at the falling edge.
  always @(negedge clock) begin
    if (!reset && outValid && outReady)
      frames.push_back('{left: outLeft, right: outRight, bs: outBlockStart});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    enable        = 1'b0;
    outReady      = 1'b0;
    clearOverflow = 1'b0;
    step();
    step();
    reset = 1'b0;
    frames.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int cyc = 0;
    while (frames.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    compared++;
    if (frames.size() < n) begin
      mismatched++;
      $display("FAIL %s timeout: got %0d frames, need %0d", name, frames.size(), n);
    end
  endtask

  task automatic wait_ticks(input int n, input int budget, input string name);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      if (sampleTick) seen++;
      step();
      cyc++;
    end
    compared++;
    if (seen < n) begin
      mismatched++;
      $display("FAIL %s timeout: got %0d ticks, need %0d", name, seen, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({outValid, overflow, sampleTick, outBlockStart} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b, need 0000", {outValid, overflow, sampleTick, outBlockStart});
    end
    compared++;
    if ({outLeft, outRight} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h, need 00000000", {outLeft, outRight});
    end
    // Fill the FIFO with three frames, then reset over them.
    waveform = 2'd0; phaseStep = 24'h400000; attenuation = 4'd0; rightInvert = 1'b0;
    enable = 1'b1;
    wait_ticks(3, 50, "reset_fill");
    step();
    compared++;
    if (outValid !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_prefill_valid: got %b, need 1", outValid);
    end
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    compared++;
    if ({outValid, overflow, sampleTick} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_midop: got %b, need 000", {outValid, overflow, sampleTick});
    end
    frames.delete();
    outReady = 1'b1;
    wait_frames(1, 50, "reset_first");
    compared++;
    if (frames[0].bs !== 1'b1 || frames[0].left !== 16'h7FFF) begin
      mismatched++;
      $display("FAIL reset_first_frame: got bs=%b left=%h, need bs=1 left=7fff", frames[0].bs, frames[0].left);
    end
    enable = 1'b0;
  endtask

  task automatic test_rate();
    int tick_cycles[$];
    int exp_first[4] = '{4, 7, 10, 14};
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      if (sampleTick) tick_cycles.push_back(c);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (tick_cycles.size() <= i || tick_cycles[i] !== exp_first[i]) begin
        mismatched++;
        $display("FAIL rate_tick%0d: got cycle %0d, need %0d", i,
                 (tick_cycles.size() > i) ? tick_cycles[i] : -1, exp_first[i]);
      end
    end
    compared++;
    if (tick_cycles.size() !== 30) begin
      mismatched++;
      $display("FAIL rate_count: got %0d ticks, need 30", tick_cycles.size());
    end
  endtask

  task automatic run_tone(input logic [1:0] wf, input logic [3:0] att, input logic inv,
                          input int n, input string name);
    do_reset();
    waveform = wf; phaseStep = 24'h400000; attenuation = att; rightInvert = inv;
    outReady = 1'b1;
    enable   = 1'b1;
    wait_frames(n, 40 * n, name);
    enable = 1'b0;
  endtask

  task automatic test_square();
    logic [15:0] exp_l[8] = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001,
                              16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};
    run_tone(2'd0, 4'd0, 1'b0, 8, "square");
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (frames[i].left !== exp_l[i] || frames[i].right !== exp_l[i]) begin
        mismatched++;
        $display("FAIL square%0d: got %h/%h, need %h/%h", i, frames[i].left, frames[i].right, exp_l[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_sawtooth_triangle();
    logic [15:0] saw[4] = '{16'hC000, 16'hE000, 16'h0000, 16'h2000};
    logic [15:0] tri_v[4] = '{16'h8000, 16'h0000, 16'h7FFE, 16'hFFFE};
    run_tone(2'd2, 4'd1, 1'b0, 4, "saw");
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (frames[i].left !== saw[i] || frames[i].right !== saw[i]) begin
        mismatched++;
        $display("FAIL saw%0d: got %h/%h, need %h/%h", i, frames[i].left, frames[i].right, saw[i], saw[i]);
      end
    end
    // Inversion: 8000 saturates to 7FFF, C000 negates to 4000.
    run_tone(2'd2, 4'd0, 1'b1, 2, "saw_inv");
    compared++;
    if (frames[0].left !== 16'h8000 || frames[0].right !== 16'h7FFF) begin
      mismatched++;
      $display("FAIL saw_inv0: got %h/%h, need 8000/7fff", frames[0].left, frames[0].right);
    end
    compared++;
    if (frames[1].left !== 16'hC000 || frames[1].right !== 16'h4000) begin
      mismatched++;
      $display("FAIL saw_inv1: got %h/%h, need c000/4000", frames[1].left, frames[1].right);
    end
    run_tone(2'd1, 4'd0, 1'b0, 4, "tri");
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (frames[i].left !== tri_v[i]) begin
        mismatched++;
        $display("FAIL tri%0d: got %h, need %h", i, frames[i].left, tri_v[i]);
      end
    end
    run_tone(2'd3, 4'd0, 1'b0, 1, "silence");
    compared++;
    if (frames[0].left !== 16'h0000 || frames[0].right !== 16'h0000) begin
      mismatched++;
      $display("FAIL silence: got %h/%h, need 0000/0000", frames[0].left, frames[0].right);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_l[4] = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};
    do_reset();
    waveform = 2'd0; phaseStep = 24'h400000; attenuation = 4'd0; rightInvert = 1'b0;
    enable = 1'b1;
    wait_ticks(5, 60, "bp_ticks");
    enable = 1'b0;
    step();
    compared++;
    if (outValid !== 1'b1 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_overflow: got valid=%b ovf=%b, need 1/1", outValid, overflow);
    end
    step();
    compared++;
    if (outLeft !== 16'h7FFF || outBlockStart !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_head_stable: got %h bs=%b, need 7fff bs=1", outLeft, outBlockStart);
    end
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_clear: got %b, need 0", overflow);
    end
    outReady = 1'b1;
    wait_frames(4, 20, "bp_drain");
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (frames[i].left !== exp_l[i] || frames[i].right !== exp_l[i] || frames[i].bs !== (i == 0)) begin
        mismatched++;
        $display("FAIL bp_frame%0d: got %h/%h bs=%b, need %h/%h bs=%b", i, frames[i].left,
                 frames[i].right, frames[i].bs, exp_l[i], exp_l[i], (i == 0));
      end
    end
    step();
    step();
    compared++;
    if (outValid !== 1'b0 || frames.size() !== 4) begin
      mismatched++;
      $display("FAIL bp_empty: got valid=%b frames=%0d, need 0/4", outValid, frames.size());
    end
  endtask

  task automatic test_block_start();
    int bs_count = 0;
    int idx[3] = '{0, 192, 384};
    run_tone(2'd2, 4'd0, 1'b0, 385, "block");
    for (int i = 0; i < 385 && i < frames.size(); i++)
      if (frames[i].bs === 1'b1) bs_count++;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (frames[idx[k]].bs !== 1'b1) begin
        mismatched++;
        $display("FAIL block_start%0d: got %b, need 1", idx[k], frames[idx[k]].bs);
      end
    end
    compared++;
    if (bs_count !== 3) begin
      mismatched++;
      $display("FAIL block_count: got %0d, need 3", bs_count);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; phaseStep = '0; waveform = '0; attenuation = '0;
    rightInvert = 1'b0; clearOverflow = 1'b0; outReady = 1'b0;
    test_reset();
    test_rate();
    test_square();
    test_sawtooth_triangle();
    test_backpressure();
    test_block_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/audio_test_tone_source.md
Name: audio_test_tone_source

Overview:
Stereo PCM test-tone source for the audio half of the A/V test-pattern top level. It runs on the pixel clock and derives the audio sample rate with a fractional accumulator. It generates square, triangle or sawtooth tones from a phase accumulator and buffers stereo frames in a small FIFO. The FIFO drains through a valid/ready stream into the HDMI audio-sample packetizer, with an IEC 60958 block-start flag every 192 frames.

Parameters:
CLOCK_HZ, 74250000, input clock frequency (integer Hz, < 2^31)
SAMPLE_RATE, 48000, audio frame rate (integer Hz, 0 < SAMPLE_RATE < CLOCK_HZ)
FIFO_DEPTH, 4, frame FIFO entries (power of two, >= 2)

Ports:
clock  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  1 = generate frames; 0 = phase held at 0, no pushes
phaseStep  in  24  phase increment per frame; f_tone = phaseStep * SAMPLE_RATE / 2^24
waveform  in  2  0 square, 1 triangle, 2 sawtooth, 3 silence
attenuation  in  4  arithmetic right shift applied to sample (0..15)
rightInvert  in  1  1 = right channel is saturated negation of left
clearOverflow  in  1  clears the overflow flag
sampleTick  out  1  one-cycle strobe at SAMPLE_RATE (debug/packet timing)
outValid  out  1  FIFO head valid
outReady  in  1  consumer accepts head when outValid & outReady
outLeft  out  16  signed left sample at FIFO head
outRight  out  16  signed right sample at FIFO head
outBlockStart  out  1  head frame is frame 0 of a 192-frame block
overflow  out  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset: rateAcc=0, phase=0, frameIndex=0, FIFO empty; sampleTick, outValid, outBlockStart, overflow = 0; outLeft and outRight = 0.
- Rate generator: 32-bit rateAcc. Each cycle, if rateAcc + SAMPLE_RATE >= CLOCK_HZ, then rateAcc <= rateAcc + SAMPLE_RATE - CLOCK_HZ and sampleTick = 1 that cycle. Otherwise rateAcc <= rateAcc + SAMPLE_RATE. The generator runs regardless of enable. There is no long-term drift: over CLOCK_HZ cycles there are exactly SAMPLE_RATE ticks.
- Tick cycle with enable=1:
  - p = phase[23:8]. phaseStep, waveform, attenuation and rightInvert are sampled this cycle.
  - Sample s (16-bit signed):
    - square: p[15]=0 -> 16'h7FFF, else 16'h8001
    - triangle: t = p[15] ? ~p[14:0] : p[14:0]; s = {t,1'b0} ^ 16'h8000
    - sawtooth: s = p ^ 16'h8000
    - silence: s = 0
  - left = s >>> attenuation (arithmetic shift).
  - right = left when rightInvert=0. When rightInvert=1, right = -left, with left = 16'h8000 mapping to 16'h7FFF.
  - phase <= phase + phaseStep, mod 2^24.
- Frame write: the computed frame is registered and pushed in the cycle after the tick, so latency is 1 cycle from tick to push. The frame carries blockStart = (frameIndex == 0).
  - frameIndex increments only on a successful push and wraps 191 -> 0.
  - If the FIFO is full on the push cycle, the frame is dropped, overflow <= 1, and frameIndex is unchanged. Phase has already advanced, so tone timing is preserved.
  - A pop and a push in the same cycle when full: the pop frees the slot and the push succeeds.
- enable=0: phase is forced to 0 and no frames are pushed. The FIFO continues to drain. On re-enable, the first frame uses phase 0.
- Output stream: outValid = FIFO not empty. outLeft, outRight and outBlockStart show the head and are combinational from FIFO storage. They must stay stable while outValid & !outReady. The head pops on outValid & outReady.
- Overflow: set on a drop. Cleared by clearOverflow unless a drop occurs in the same cycle; set wins.
- Reset mid-operation: FIFO contents are discarded and every state element returns to its reset value on the next edge. No partial frame is emitted.

Test Plan:
- Reset: assert reset for 2 cycles with the FIFO holding 3 frames -> outValid=0, overflow=0, sampleTick=0 on the following cycle; the first pushed frame after release has outBlockStart=1.
- Rate: CLOCK_HZ=100, SAMPLE_RATE=30 -> first tick on cycle 4 after reset release, then ticks spaced 3,3,4,... Exactly 30 ticks in 100 cycles.
- Square: waveform=0, phaseStep=24'h400000, attenuation=0, outReady=1 -> left = 7FFF, 7FFF, 8001, 8001, repeating; right equals left.
- Sawtooth: waveform=2, phaseStep=24'h400000, attenuation=1 -> left = C000, E000, 0000, 2000. With rightInvert=1 and attenuation=0, the first frame is left=8000, right=7FFF.
- Backpressure: FIFO_DEPTH=4, outReady=0, 5 ticks -> outValid=1, 4 frames held, 5th dropped, overflow=1. Pulse clearOverflow -> overflow=0. Release outReady -> 4 frames emerge in order with correct values.
- Block start: outReady=1, 385 frames -> outBlockStart=1 on frames 0, 192 and 384 only.
